// File: rtl/lsu_mmio_if.sv
// Core-side request/response and data-memory signals of the load/store unit.
// slave is the unit itself; master is the core plus the data memory.
interface lsu_mmio_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misalign;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
    output req_ready, rsp_valid, rsp_rdata, misalign, mem_we, mem_a, mem_wd
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
    input  req_ready, rsp_valid, rsp_rdata, misalign, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/lsu_mmio.sv
// Load/store unit: byte/half/word accesses onto a word-wide data memory
// (read-modify-write for sub-word stores), plus LED and cycle-counter registers.
module lsu_mmio #(
  parameter int unsigned DMEM_WORDS = 64,
  parameter logic [31:0] LED_ADDR   = 32'h0000_1000,
  parameter logic [31:0] CNT_ADDR   = 32'h0000_1004
) (
  input  logic      clk,
  input  logic      reset_n,
  lsu_mmio_if.slave bus,
  output logic      led
);

  typedef enum logic [1:0] {IDLE, EXEC, WRITE, RESP} state_t;

  localparam logic [29:0] DMEM_LIMIT = 30'(DMEM_WORDS);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misalign_q, misalign_d;
  logic        led_q, led_d;
  logic [31:0] cnt_q, cnt_d;

  logic        is_byte, is_half, is_word;
  logic        mis, is_led, is_cnt, in_range;
  logic [4:0]  shamt;
  logic [31:0] lane, load_data, mask, sdata, merged;
  logic        mem_we_raw;
  logic [31:0] mem_wd_c;

  assign is_byte  = (size_q == 2'b00);
  assign is_half  = (size_q == 2'b01);
  assign is_word  = size_q[1];
  assign mis      = (is_half && addr_q[0]) || (is_word && (addr_q[1:0] != 2'b00));
  assign is_led   = (addr_q == LED_ADDR);
  assign is_cnt   = (addr_q == CNT_ADDR);
  assign in_range = (addr_q[31:2] < DMEM_LIMIT);

  // One shift amount serves both load lane extraction and store lane insertion.
  always_comb begin
    shamt = '0;
    if (is_byte)      shamt = {addr_q[1:0], 3'b000};
    else if (is_half) shamt = {addr_q[1], 4'b0000};
    lane = bus.mem_rd >> shamt;
    if (is_byte) begin
      load_data = uns_q ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      mask      = 32'h0000_00FF << shamt;
      sdata     = {24'h0, wdata_q[7:0]} << shamt;
    end else if (is_half) begin
      load_data = uns_q ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      mask      = 32'h0000_FFFF << shamt;
      sdata     = {16'h0, wdata_q[15:0]} << shamt;
    end else begin
      load_data = lane;
      mask      = '1;
      sdata     = wdata_q;
    end
    merged = (merge_q & ~mask) | (sdata & mask);
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    we_d       = we_q;
    uns_d      = uns_q;
    merge_d    = merge_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    led_d      = led_q;
    cnt_d      = cnt_q + 32'd1;
    mem_we_raw = 1'b0;
    mem_wd_c   = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          size_d  = bus.req_size;
          we_d    = bus.req_we;
          uns_d   = bus.req_unsigned;
          state_d = EXEC;
        end
      end
      EXEC: begin
        misalign_d = mis;
        rdata_d    = '0;
        state_d    = RESP;
        if (!mis) begin
          if (is_led) begin
            if (we_q) led_d   = wdata_q[0];
            else      rdata_d = {31'h0, led_q};
          end else if (is_cnt) begin
            if (!we_q) rdata_d = cnt_q;
          end else if (in_range) begin
            if (!we_q) begin
              rdata_d = load_data;
            end else if (is_word) begin
              mem_we_raw = 1'b1;
              mem_wd_c   = wdata_q;
            end else begin
              merge_d = bus.mem_rd;
              state_d = WRITE;
            end
          end
        end
      end
      WRITE: begin
        mem_we_raw = 1'b1;
        mem_wd_c   = merged;
        state_d    = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      merge_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      led_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      we_q       <= we_d;
      uns_q      <= uns_d;
      merge_q    <= merge_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      led_q      <= led_d;
      cnt_q      <= cnt_d;
    end
  end

  // Write enable is gated by reset so a reset landing in EXEC/WRITE never writes.
  assign bus.mem_we    = mem_we_raw & reset_n;
  assign bus.mem_wd    = mem_wd_c;
  assign bus.mem_a     = {addr_q[31:2], 2'b00};
  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.misalign  = misalign_q & (state_q == RESP);
  assign led           = led_q;

endmodule

// File: doc/lsu_mmio.md
# lsu_mmio

Load/store unit between the single-cycle core's memory-access path and the word-wide data memory, which has a combinational read and a synchronous word write. It converts byte, halfword and word requests into word accesses, using a two-cycle read-modify-write for sub-word stores. It sign- or zero-extends load data and flags misaligned accesses. It also decodes two memory-mapped registers: an LED register and a free-running cycle counter.

## Interface
- DMEM_WORDS, 64: number of 32-bit words in data memory; valid word index is addr[31:2] < DMEM_WORDS.
- LED_ADDR, 32'h0000_1000: byte address of the LED register.
- CNT_ADDR, 32'h0000_1004: byte address of the read-only cycle counter.

- clk  in  1  clock; all state updates on posedge clk.
- reset_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle pulse marking request completion.
- rsp_rdata  out  32  extended load data; 0 for stores.
- misalign  out  1  high together with rsp_valid when the request was misaligned.
- mem_we  out  1  data-memory word write enable.
- mem_a  out  32  data-memory byte address, with bits [1:0] forced to 0.
- mem_wd  out  32  data-memory write data.
- mem_rd  in  32  data-memory combinational read data.
- led  out  1  LED register bit 0.

## Operation
- FSM states: IDLE, EXEC, WRITE, RESP.
  - IDLE: req_ready = 1. When req_valid is high, latch addr, wdata, size, we and unsigned, then go to EXEC.
  - EXEC: mem_a = {addr[31:2], 2'b00}.
    - Misaligned request: no access, go to RESP with misalign set.
    - Load: latch the formatted result, go to RESP.
    - Word store to dmem: mem_we = 1, mem_wd = wdata, go to RESP.
    - Sub-word store to dmem: latch mem_rd into the merge register, go to WRITE.
    - MMIO access: handled in EXEC, go to RESP.
  - WRITE: mem_we = 1, mem_wd = merge word with the target lane replaced, go to RESP.
  - RESP: rsp_valid = 1 for one cycle, go to IDLE. req_ready = 0 in every state except IDLE.
- Misaligned: a half access with addr[0] = 1, or a word access with addr[1:0] != 0. No dmem or MMIO side effect. rsp_rdata = 0, misalign = 1.
- Byte lanes:
  - Byte lane = addr[1:0]; half lane = addr[1] (bits [15:0] or [31:16]).
  - Stores take bytes from the low bits of wdata.
  - Loads shift the lane to bit 0, then extend per req_unsigned. Word loads are not extended.
- MMIO decode compares the full 32-bit address:
  - LED_ADDR: a store of any size sets led <= wdata[0]. A load returns {31'b0, led}.
  - CNT_ADDR: a load returns the counter. Stores are ignored.
  - The counter is 32 bits, increments every cycle, and wraps from FFFF_FFFF to 0.
  - mem_we stays 0 for every MMIO access.
- Out of range (not MMIO and addr[31:2] >= DMEM_WORDS): loads return 0, stores are dropped, misalign stays 0.

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, misalign 0, led 0, counter 0, mem_we 0. The counter reads 0 in the first cycle after reset is released.
- mem_we is combinationally gated by reset_n. No write is issued in any cycle where reset_n = 0. Reset in EXEC or WRITE aborts the request, and no rsp_valid follows.
- Latency, with the request accepted at edge N:
  - Load, word store, MMIO access or misaligned request: rsp_valid high in cycle N+2.
  - Sub-word store: rsp_valid high in cycle N+3.
- The dmem write lands at the edge ending EXEC (word store) or WRITE (sub-word store). A load issued right after a store sees the new data.
- The core must hold req_* stable only in the accept cycle. Inputs are ignored while req_ready = 0.
- The counter value returned is the value sampled in EXEC.
- A led write takes effect at the edge ending EXEC.

## Test plan
- Word store then load: store 0xDEADBEEF to 0x10, then load word from 0x10 -> mem_we pulses once, rsp_rdata = 0xDEADBEEF, rsp_valid two cycles after each accept.
- Byte read-modify-write: memory word at 0x10 = 0x11223344; store byte 0xAA to 0x12 -> one mem_we pulse with mem_wd = 0x11AA3344, rsp_valid in cycle N+3. Then a signed byte load from 0x12 returns 0xFFFFFFAA; an unsigned byte load returns 0x000000AA.
- Halfword extension: word at 0x20 = 0x8001_7FFF -> signed half load from 0x22 returns 0xFFFF8001; signed half load from 0x20 returns 0x00007FFF.
- Misalignment: word store to 0x21 and half load from 0x23 -> misalign = 1 with rsp_valid, no mem_we, memory unchanged, rsp_rdata = 0.
- MMIO: store 0x1 to LED_ADDR -> led = 1 with no mem_we. Load from LED_ADDR -> returns 1. Two loads from CNT_ADDR issued back to back -> the difference equals the cycle spacing between their EXEC states. Store to CNT_ADDR -> counter keeps counting.
- Reset mid-RMW: assert reset_n = 0 during WRITE -> no mem_we, no rsp_valid, led = 0, req_ready = 1 in the first cycle after release.
